// File: rtl/mux_arb_pkg.sv
// Shared types for the two-channel round-robin mux arbiter.
package mux_arb_pkg;

   typedef logic chan_t;

   localparam chan_t CH0 = 1'b0;
   localparam chan_t CH1 = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } stage_t;

endpackage

// File: rtl/rr_grant2.sv
// Combinational 2-way round-robin picker with optional packet-lock override.
module rr_grant2
   import mux_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  chan_t      last_grant,
   input  logic       lock,
   input  logic       can_accept,
   output logic [1:0] grant,
   output chan_t      grant_idx
);

   logic cand_valid;

   always_comb begin
      grant_idx  = CH0;
      cand_valid = 1'b0;
      if (lock) begin
         // Locked channel keeps the grant even when idle; the other channel waits.
         grant_idx  = last_grant;
         cand_valid = valid[last_grant];
      end else if (valid == 2'b11) begin
         grant_idx  = ~last_grant;
         cand_valid = 1'b1;
      end else if (valid[1]) begin
         grant_idx  = CH1;
         cand_valid = 1'b1;
      end else if (valid[0]) begin
         grant_idx  = CH0;
         cand_valid = 1'b1;
      end
   end

   always_comb begin
      grant = '0;
      if (can_accept && cand_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Two-channel round-robin arbiter with a one-entry registered output stage.
// Optional packet lock enabled by defining MUX_ARB_PACKET_LOCK_EN.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s0_valid,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_last,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_last,
   output logic              s1_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              sel
);

   stage_t            state;
   chan_t             last_grant;
   logic              lock;
   logic              can_accept;
   logic              accept;
   logic [1:0]        grant;
   chan_t             grant_idx;
   logic [DATA_W-1:0] win_data;
   logic              win_last;

   assign m_valid    = (state == FULL);
   assign can_accept = !m_valid || m_ready;

   rr_grant2 u_rr_grant2 (
      .valid      ({s1_valid, s0_valid}),
      .last_grant (last_grant),
      .lock       (lock),
      .can_accept (can_accept),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign s0_ready = grant[0];
   assign s1_ready = grant[1];
   assign accept   = |grant;
   assign win_data = (grant_idx == CH1) ? s1_data : s0_data;
   assign win_last = (grant_idx == CH1) ? s1_last : s0_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         m_data     <= '0;
         m_last     <= 1'b0;
         sel        <= CH0;
         last_grant <= CH1;
      end else if (accept) begin
         state      <= FULL;
         m_data     <= win_data;
         m_last     <= win_last;
         sel        <= grant_idx;
         last_grant <= grant_idx;
      end else if (m_ready) begin
         state <= EMPTY;
      end
   end

`ifdef MUX_ARB_PACKET_LOCK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock <= 1'b0;
      end else if (accept) begin
         lock <= !win_last;
      end
   end
`else
   assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (honours MUX_ARB_PACKET_LOCK_EN).
module tb_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0_valid, s0_last, s0_ready;
   logic [7:0] s0_data;
   logic       s1_valid, s1_last, s1_ready;
   logic [7:0] s1_data;
   logic       m_valid, m_last, m_ready, sel;
   logic [7:0] m_data;

   int unsigned total = 0;
   int unsigned fails = 0;

   mux_arbiter #(.DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s0_valid (s0_valid),
      .s0_data  (s0_data),
      .s0_last  (s0_last),
      .s0_ready (s0_ready),
      .s1_valid (s1_valid),
      .s1_data  (s1_data),
      .s1_last  (s1_last),
      .s1_ready (s1_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .sel      (sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic s);
      chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, v});
      chk({tag, ".m_data"},  {24'd0, m_data},  {24'd0, d});
      chk({tag, ".m_last"},  {31'd0, m_last},  {31'd0, l});
      chk({tag, ".sel"},     {31'd0, sel},     {31'd0, s});
   endtask

   task automatic chk_rdy(input string tag, input logic r0, input logic r1);
      #1;
      chk({tag, ".s0_ready"}, {31'd0, s0_ready}, {31'd0, r0});
      chk({tag, ".s1_ready"}, {31'd0, s1_ready}, {31'd0, r1});
   endtask

   logic [7:0] exp_d [4];
   logic       exp_l [4];
   logic       exp_s [4];
   logic [7:0] pkt_d [3];
   logic       pkt_l [3];
   int unsigned idx;

   initial begin
      rst_n = 1'b0; m_ready = 1'b0;
      s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
      s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
      tick(); tick();
      chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
      chk_rdy("reset", 1'b0, 1'b0);
      rst_n = 1'b1;

      // 1: single beat on channel 0
      s0_valid = 1'b1; s0_data = 8'h11; m_ready = 1'b1;
      chk_rdy("t1", 1'b1, 1'b0);
      tick();
      chk_out("t1", 1'b1, 8'h11, 1'b0, 1'b0);

      // idle channel 1 accepted the same cycle it is valid
      s0_valid = 1'b0; s1_valid = 1'b1; s1_data = 8'h0C;
      chk_rdy("t1b", 1'b0, 1'b1);
      tick();
      chk_out("t1b", 1'b1, 8'h0C, 1'b0, 1'b1);

      // 2: continuous contention alternates starting with channel 0
      s0_valid = 1'b1; s0_data = 8'h0A; s1_data = 8'h0B;
      for (int i = 0; i < 6; i++) begin
         chk_rdy("t2", (i % 2) == 0, (i % 2) == 1);
         tick();
         chk_out("t2", 1'b1, (i % 2 == 0) ? 8'h0A : 8'h0B, 1'b0, (i % 2) == 1);
      end

      // 3: stall while FULL with 0x22
      s1_valid = 1'b0; s0_data = 8'h22;
      chk_rdy("t3load", 1'b1, 1'b0);
      tick();
      chk_out("t3load", 1'b1, 8'h22, 1'b0, 1'b0);
      s0_valid = 1'b0; s1_valid = 1'b1; s1_data = 8'h44; m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_rdy("t3stall", 1'b0, 1'b0);
         tick();
         chk_out("t3stall", 1'b1, 8'h22, 1'b0, 1'b0);
      end
      m_ready = 1'b1;
      chk_rdy("t3release", 1'b0, 1'b1);
      tick();
      chk_out("t3release", 1'b1, 8'h44, 1'b0, 1'b1);

      // 4: drain and refill in the same cycle, then drain to empty
      s1_valid = 1'b0; s0_valid = 1'b1; s0_data = 8'h55;
      chk_rdy("t4a", 1'b1, 1'b0);
      tick();
      chk_out("t4a", 1'b1, 8'h55, 1'b0, 1'b0);
      s0_data = 8'h66;
      tick();
      chk_out("t4b", 1'b1, 8'h66, 1'b0, 1'b0);
      s0_valid = 1'b0;
      chk_rdy("t4drain", 1'b0, 1'b0);
      tick();
      chk_out("t4drain", 1'b0, 8'h66, 1'b0, 1'b0);

      // 5: packet of three s0 beats against a continuously valid s1
      s1_valid = 1'b1; s1_data = 8'h77; s1_last = 1'b1;
      tick();
      chk_out("t5pre", 1'b1, 8'h77, 1'b1, 1'b1);
      pkt_d = '{8'hA1, 8'hA2, 8'hA3};
      pkt_l = '{1'b0, 1'b0, 1'b1};
`ifdef MUX_ARB_PACKET_LOCK_EN
      exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h77};
      exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
      exp_d = '{8'hA1, 8'h77, 8'hA2, 8'h77};
      exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      idx = 0;
      for (int i = 0; i < 4; i++) begin
         s0_valid = (idx < 3);
         s0_data  = (idx < 3) ? pkt_d[idx] : 8'h00;
         s0_last  = (idx < 3) ? pkt_l[idx] : 1'b0;
         #1;
         if (s0_ready) idx++;
         tick();
         chk_out("t5", 1'b1, exp_d[i], exp_l[i], exp_s[i]);
      end
      s0_valid = 1'b0; s0_last = 1'b0; s1_valid = 1'b0; s1_last = 1'b0;

      // 6: reset while FULL discards the beat; first contention goes to channel 0
      s0_valid = 1'b1; s0_data = 8'h33;
      tick();
      chk_out("t6load", 1'b1, 8'h33, 1'b0, 1'b0);
      s0_valid = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
      tick();
      chk_out("t6reset", 1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1; m_ready = 1'b1;
      s0_valid = 1'b1; s0_data = 8'h81; s1_valid = 1'b1; s1_data = 8'h82;
      chk_rdy("t6cont", 1'b1, 1'b0);
      tick();
      chk_out("t6cont", 1'b1, 8'h81, 1'b0, 1'b0);
      s0_valid = 1'b0; s1_valid = 1'b0;

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-channel round-robin arbiter that sits directly upstream of the 2:1 data mux and decides which source is forwarded each cycle. Each source has a valid/ready handshake. The block registers the winning beat into a one-entry output stage and exports the winning channel index as `sel`, so the downstream mux select is always consistent with the held data. Fairness is strict alternation under contention; an optional packet lock keeps the grant until the end of a packet.

## Interface
- `DATA_W`, default 8: payload width of each channel and of the output.
- `clk`  in  1  rising-edge clock; the only clock domain.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `s0_valid`  in  1  channel 0 has a beat.
- `s0_data`  in  DATA_W  channel 0 payload.
- `s0_last`  in  1  channel 0 end-of-packet marker.
- `s0_ready`  out  1  channel 0 beat accepted this cycle.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`: same as channel 0, for channel 1.
- `m_valid`  out  1  the output register holds a beat.
- `m_data`  out  DATA_W  held payload.
- `m_last`  out  1  held end-of-packet marker.
- `m_ready`  in  1  consumer takes the held beat this cycle.
- `sel`  out  1  channel index of the held beat; drives the downstream mux select.

## Operation
- **Reset values:**
  - Outputs: `m_valid`=0, `m_data`=0, `m_last`=0, `sel`=0.
  - Internal: `last_grant`=1, so channel 0 wins the first contention.
  - Lock state: cleared.
- **Output stage states:**
  - EMPTY: `m_valid`=0.
  - FULL: `m_valid`=1.
- **Capacity:**
  - `can_accept` = !`m_valid` | `m_ready`.
  - An accept in the same cycle as a drain keeps the stage FULL with the new beat.
- **Arbitration (combinational, evaluated every cycle):**
  - Only one valid: that channel is the candidate.
  - Both valid: the channel != `last_grant` is the candidate.
  - Neither valid: no grant.
- **Ready:**
  - `sN_ready` = `can_accept` & (candidate == N).
  - At most one `sN_ready` is high per cycle.
  - `sN_ready` may depend combinationally on `m_ready`. There is no combinational path from `sN_valid` to `sN_ready` of the same channel other than through arbitration.
- **On accept:**
  - `m_data`/`m_last` load the winner's data/last.
  - `sel` and `last_grant` load the winner's index.
  - `m_valid` is set to 1.
- **Drain without accept:** FULL → EMPTY; `m_data`, `m_last` and `sel` keep their values.
- **Stall** (FULL & !`m_ready`):
  - `m_data`, `m_last`, `sel` and `m_valid` are held stable.
  - Both readies are 0.
- **Producer rule:** source data must stay stable while `valid` & !`ready`; the block does not check this.
- **Reset mid-operation:** a held beat is discarded, with no drain, and all state returns to reset values on the next edge.

## Timing
- Latency from accept to `m_valid` is 1 cycle.
- Throughput is 1 beat/cycle when `m_ready` is held high.
- Under continuous contention with `m_ready`=1, grants alternate every cycle: 0, 1, 0, 1, …
- A beat arriving on the idle channel is accepted in the same cycle it becomes valid if `can_accept` is high.
- `sel` changes only on the edge that loads a new beat.

## Configuration
- Macro: `MUX_ARB_PACKET_LOCK_EN`.
- **Defined:**
  - Accepting a beat with `last`=0 sets `lock`.
  - While `lock` is set, the candidate is forced to `last_grant` regardless of the other channel's `valid`, and the locked channel may stall freely.
  - Accepting a beat with `last`=1 clears `lock`.
  - Round-robin resumes from that point.
- **Undefined:**
  - `lock` logic is absent and the `last` inputs affect only `m_last`.
  - Arbitration is per beat.

## Structure
- **Package `mux_arb_pkg`:**
  - `chan_t`, a 1-bit channel index.
  - Constants `CH0`=0 and `CH1`=1.
  - Output-stage state enum `EMPTY`/`FULL`.
- **Sub-module `rr_grant2`:**
  - Combinational 2-way round-robin picker.
  - Inputs: `valid[1:0]`, `last_grant`, `lock`, `can_accept`.
  - Outputs: `grant[1:0]` (one-hot) and `grant_idx`.
- The top level holds the output register, `last_grant`, and `lock`.

## Test plan
1. Reset, then `s0_valid`=1 with `s0_data`=0x11 and `m_ready`=1 → `s0_ready`=1; next cycle `m_valid`=1, `m_data`=0x11, `sel`=0.
2. Both channels valid continuously (s0 0x0A, s1 0x0B) with `m_ready`=1 for 6 cycles → `m_data` sequence 0A, 0B, 0A, 0B, 0A, 0B and `sel` toggles each cycle.
3. Output FULL with 0x22 and `m_ready`=0 for 3 cycles while s1 is valid → `m_data` stays 0x22, both readies 0; on raising `m_ready`, s1 is accepted in the same cycle and `m_data` updates on the next edge.
4. Drain-and-refill in the same cycle (`m_ready`=1, `s0_valid`=1) → `m_valid` stays 1 across the boundary and no bubble appears.
5. With `MUX_ARB_PACKET_LOCK_EN`: s0 sends 3 beats with `last` on the third while s1 is continuously valid → three s0 beats, then s1; without the macro → the beats alternate.
6. `rst_n`=0 asserted while FULL with 0x33 → next cycle `m_valid`=0 and `m_data`=0; the first contention after reset grants channel 0.
